// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request sequencer.
// Holds the sequencer state encoding, default widths and the default
// timeout, plus a helper that says which states drive the core.
package gcd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD_A = 3'd1;
  localparam state_t S_LOAD_B = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_RESP   = 3'd4;

  localparam int GCD_W       = 16;
  localparam int GCD_TIMEOUT = 1023;
  localparam int GCD_CW      = 10;

  // States in which the core controller sees start held high.
  function automatic logic drives_core(input state_t s);
    return (s == S_LOAD_A) || (s == S_LOAD_B) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/gcd_timeout_cnt.sv
// Watchdog counter for the sequencer's WAIT state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (has priority over en)
//   en         : count one per cycle
//   expired    : count == TIMEOUT-1 while en is high
module gcd_timeout_cnt #(
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_req_seq.sv
// Upstream request sequencer for the subtractive GCD core.
// Takes one operand pair over a valid/ready handshake, feeds A then B onto
// the core's data bus with start held, waits for done (bounded by a
// watchdog), and returns the result over a valid/ready handshake. Zero
// operands are answered locally since the core never finishes on them.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b   : operand-pair request
//   out_valid/out_ready/out_gcd   : result response
//   out_err                       : result aborted by timeout (with out_valid)
//   busy                          : transaction in flight
//   core_start/core_data          : drive the core controller and data_in
//   core_done/core_result         : core completion and A-register output
module gcd_req_seq
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = GCD_TIMEOUT,
  parameter int CW      = GCD_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_err,
  output logic         busy,
  output logic         core_start,
  output logic [W-1:0] core_data,
  input  logic         core_done,
  input  logic [W-1:0] core_result
);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   gcd_q, gcd_d;
  logic           err_q, err_d;
  logic           cnt_clr;
  logic           cnt_en;
  logic           expired;

  gcd_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      // NOTE: the operand registers are few and small, so they are reset
      // like the rest; core_data then reads as zero straight out of reset.
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // gcd(x,0) = x, and the OR yields the nonzero operand (or 0).
            gcd_d   = in_a | in_b;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_WAIT;
      S_WAIT: begin
        // A done in the expiry cycle still wins: the result is good.
        if (core_done) begin
          gcd_d   = core_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (expired) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so reset drops
  // core_start asynchronously and no input feeds an output directly.
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_RESP);
    busy       = (state_q != S_IDLE);
    core_start = drives_core(state_q);
    cnt_clr    = (state_q == S_LOAD_B);
    cnt_en     = (state_q == S_WAIT);
    core_data  = '0;
    if (state_q == S_LOAD_A) begin
      core_data = a_q;
    end else if ((state_q == S_LOAD_B) || (state_q == S_WAIT)) begin
      core_data = b_q;
    end
  end

  assign out_gcd = gcd_q;
  assign out_err = err_q;

endmodule

// File: tb/tb_gcd_req_seq.sv
// Bench for gcd_req_seq with TIMEOUT=16. A small behavioural subtractive
// GCD core answers the sequencer; a stub override drives core_done and
// core_result directly for the timeout corner cases.
module tb_gcd_req_seq;

  localparam int W       = 16;
  localparam int TIMEOUT = 16;
  localparam int CW      = 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;
  logic         core_start;
  logic [W-1:0] core_data;
  logic         core_done;
  logic [W-1:0] core_result;

  int n_cmp  = 0;
  int n_fail = 0;

  gcd_req_seq #(
    .W       (W),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err),
    .busy        (busy),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: latch A, then B, then one subtract step per cycle
  // while start stays high; done once the two registers agree.
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_phase;
  logic         m_done;
  logic         stub_en;
  logic         stub_done;
  logic [W-1:0] stub_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_phase <= 2'd0; m_done <= 1'b0;
    end else if (!core_start) begin
      m_phase <= 2'd0; m_done <= 1'b0;
    end else if (m_phase == 2'd0) begin
      m_a <= core_data; m_phase <= 2'd1;
    end else if (m_phase == 2'd1) begin
      m_b <= core_data; m_phase <= 2'd2;
    end else if (m_a == m_b) begin
      m_done <= 1'b1;
    end else if (m_a > m_b) begin
      m_a <= m_a - m_b;
    end else begin
      m_b <= m_b - m_a;
    end
  end

  assign core_done   = stub_en ? stub_done   : m_done;
  assign core_result = stub_en ? stub_result : m_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a pair at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, counting cycles with core_start high.
  task automatic wait_out(output int starts);
    starts = 0;
    for (int i = 0; i < 200 && !out_valid; i++) begin
      if (core_start) starts++;
      @(negedge clk);
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_gcd;
    logic         bypass;
  } vec_t;

  vec_t vecs[8];
  int   starts;
  int   seen;

  initial begin
    vecs[0] = '{a: 16'd143, b: 16'd78,  exp_gcd: 16'd13, bypass: 1'b0};
    vecs[1] = '{a: 16'd0,   b: 16'd45,  exp_gcd: 16'd45, bypass: 1'b1};
    vecs[2] = '{a: 16'd60,  b: 16'd0,   exp_gcd: 16'd60, bypass: 1'b1};
    vecs[3] = '{a: 16'd0,   b: 16'd0,   exp_gcd: 16'd0,  bypass: 1'b1};
    vecs[4] = '{a: 16'd100, b: 16'd75,  exp_gcd: 16'd25, bypass: 1'b0};
    vecs[5] = '{a: 16'd17,  b: 16'd5,   exp_gcd: 16'd1,  bypass: 1'b0};
    vecs[6] = '{a: 16'd7,   b: 16'd7,   exp_gcd: 16'd7,  bypass: 1'b0};
    vecs[7] = '{a: 16'd12,  b: 16'd8,   exp_gcd: 16'd4,  bypass: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    stub_en = 1'b0; stub_done = 1'b0; stub_result = '0;
    #1;
    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_out_gcd",    {16'd0, out_gcd},    32'd0);
    check("rst_core_data",  {16'd0, core_data},  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transactions with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b);
      if (vecs[i].bypass) begin
        check($sformatf("v%0d_bypass_valid", i), {31'd0, out_valid}, 32'd1);
        check($sformatf("v%0d_bypass_nostart", i), {31'd0, core_start}, 32'd0);
      end else begin
        wait_out(starts);
      end
      check($sformatf("v%0d_gcd", i), {16'd0, out_gcd}, {16'd0, vecs[i].exp_gcd});
      check($sformatf("v%0d_err", i), {31'd0, out_err}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_idle_ready", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("v%0d_valid_drop", i), {31'd0, out_valid}, 32'd0);
    end

    // Nominal load sequence: A then B on consecutive cycles.
    send(16'd143, 16'd78);
    check("nom_start_a", {31'd0, core_start}, 32'd1);
    check("nom_data_a",  {16'd0, core_data},  32'd143);
    check("nom_busy",    {31'd0, busy},       32'd1);
    check("nom_in_ready", {31'd0, in_ready},  32'd0);
    @(negedge clk);
    check("nom_data_b",  {16'd0, core_data},  32'd78);
    @(negedge clk);
    check("nom_wait_start", {31'd0, core_start}, 32'd1);
    check("nom_wait_data",  {16'd0, core_data},  32'd78);
    wait_out(starts);
    check("nom_gcd", {16'd0, out_gcd}, 32'd13);
    @(negedge clk);

    // Backpressure: result held for 5 cycles, new requests ignored.
    out_ready = 1'b0;
    send(16'd48, 16'd18);
    wait_out(starts);
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd3;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_gcd_%0d", i),   {16'd0, out_gcd},   32'd6);
      check($sformatf("bp_ready_%0d", i), {31'd0, in_ready},  32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready},  32'd1);

    // Core ignored while idle.
    stub_en = 1'b1; stub_done = 1'b1; stub_result = 16'd99;
    repeat (3) @(negedge clk);
    check("idle_done_ignored", {31'd0, out_valid}, 32'd0);
    check("idle_done_busy",    {31'd0, busy},      32'd0);

    // Timeout: done never comes; 2 load + 16 wait cycles with start high.
    stub_done = 1'b0;
    send(16'd9, 16'd6);
    wait_out(starts);
    check("to_start_cycles", starts, 32'd18);
    check("to_err",   {31'd0, out_err},    32'd1);
    check("to_gcd",   {16'd0, out_gcd},    32'd0);
    check("to_start_low", {31'd0, core_start}, 32'd0);
    @(negedge clk);

    // Done arrives exactly in the expiry cycle: done wins.
    send(16'd9, 16'd6);
    starts = 0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (core_start) starts++;
      stub_done   = (starts == 18);
      stub_result = 16'd7;
      @(negedge clk);
    end
    stub_done = 1'b0;
    check("sim_valid", {31'd0, out_valid}, 32'd1);
    check("sim_start_cycles", starts, 32'd18);
    check("sim_gcd", {16'd0, out_gcd}, 32'd7);
    check("sim_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    stub_en = 1'b0;

    // Reset in the middle of WAIT.
    send(16'd143, 16'd78);
    repeat (3) @(negedge clk);
    check("rw_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_core_start", {31'd0, core_start}, 32'd0);
    check("rw_busy",       {31'd0, busy},       32'd0);
    check("rw_in_ready",   {31'd0, in_ready},   32'd1);
    check("rw_out_gcd",    {16'd0, out_gcd},    32'd0);
    check("rw_core_data",  {16'd0, core_data},  32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rw_no_out_valid", seen, 32'd0);
    send(16'd12, 16'd8);
    wait_out(starts);
    check("rw_next_gcd", {16'd0, out_gcd}, 32'd4);
    check("rw_next_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
